// File: rtl/instr_encoder.sv
// instr_encoder: streaming LEGv8 encoder for LDUR, STUR and CBZ.
// Range-checks the immediate, packs a 32-bit instruction word into a single
// output register stage and tags it with a sequential word address.
// Rejected requests do not load the output; they pulse err and bump err_cnt.
//
// Handshake (both sides): a transfer happens on a rising edge where valid and
// ready are both high; valid never depends on ready, and once out_valid is
// high out_instr/out_addr hold until the word is taken or clear/reset drops it.
module instr_encoder #(
  parameter int ADDR_W = 8,
  parameter int ERR_W  = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        in_op,
  input  logic [4:0]        in_rt,
  input  logic [4:0]        in_rn,
  input  logic [63:0]       in_imm,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_instr,
  output logic [ADDR_W-1:0] out_addr,
  output logic              err,
  output logic [ERR_W-1:0]  err_cnt
);

  localparam logic [1:0] OP_LDUR = 2'b00;
  localparam logic [1:0] OP_STUR = 2'b01;
  localparam logic [1:0] OP_CBZ  = 2'b10;

  logic              r_out_valid;
  logic [31:0]       r_out_instr;
  logic [ADDR_W-1:0] r_out_addr;
  logic [ADDR_W-1:0] r_next_addr;
  logic              r_err;
  logic [ERR_W-1:0]  r_err_cnt;

  logic              w_accept;
  logic              w_consume;
  logic              w_load;
  logic              w_reject;
  logic              w_ldst_ok;
  logic              w_cbz_ok;
  logic              w_imm_ok;
  logic [31:0]       w_instr;

  // A new request may enter whenever the output slot is empty or being drained
  // in the same cycle; clear blocks intake so nothing is silently dropped.
  assign in_ready  = !clear && (!r_out_valid || out_ready);
  assign w_accept  = in_valid && in_ready;
  assign w_consume = r_out_valid && out_ready;

  // D-format offsets are 9-bit signed; CBZ offsets are 21-bit signed and word aligned.
  assign w_ldst_ok = (in_imm[63:8] == {56{in_imm[8]}});
  assign w_cbz_ok  = (in_imm[1:0] == 2'b00) && (in_imm[63:20] == {44{in_imm[20]}});

  // Select the range check and pack the instruction word for the requested op.
  always_comb begin
    w_imm_ok = 1'b0;
    w_instr  = 32'h0;
    case (in_op)
      OP_LDUR: begin
        w_imm_ok = w_ldst_ok;
        w_instr  = {11'b11111000010, in_imm[8:0], 2'b00, in_rn, in_rt};
      end
      OP_STUR: begin
        w_imm_ok = w_ldst_ok;
        w_instr  = {11'b11111000000, in_imm[8:0], 2'b00, in_rn, in_rt};
      end
      OP_CBZ: begin
        w_imm_ok = w_cbz_ok;
        w_instr  = {8'b10110100, in_imm[20:2], in_rt};
      end
      default: begin
        w_imm_ok = 1'b0;
        w_instr  = 32'h0;
      end
    endcase
  end

  assign w_load   = w_accept && w_imm_ok;
  assign w_reject = w_accept && !w_imm_ok;

  // Output register: load on a valid accept, otherwise drop valid once consumed.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_out_valid <= 1'b0;
      r_out_instr <= 32'h0;
      r_out_addr  <= '0;
    end else if (clear) begin
      r_out_valid <= 1'b0;
    end else if (w_load) begin
      r_out_valid <= 1'b1;
      r_out_instr <= w_instr;
      r_out_addr  <= r_next_addr;
    end else if (w_consume) begin
      r_out_valid <= 1'b0;
    end
  end

  // Word-address counter: advances only for words that are actually emitted.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_next_addr <= '0;
    end else if (clear) begin
      r_next_addr <= '0;
    end else if (w_load) begin
      r_next_addr <= r_next_addr + 1'b1;
    end
  end

  // Error pulse and saturating error counter for rejected requests.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_err     <= 1'b0;
      r_err_cnt <= '0;
    end else if (clear) begin
      r_err     <= 1'b0;
      r_err_cnt <= '0;
    end else begin
      r_err <= w_reject;
      if (w_reject && (r_err_cnt != {ERR_W{1'b1}})) begin
        r_err_cnt <= r_err_cnt + 1'b1;
      end
    end
  end

  assign out_valid = r_out_valid;
  assign out_instr = r_out_instr;
  assign out_addr  = r_out_addr;
  assign err       = r_err;
  assign err_cnt   = r_err_cnt;

endmodule

// File: tb/tb_instr_encoder.sv
// Bench for instr_encoder: directed vectors drive requests, expected words are
// queued at accept time and an independent monitor pops and compares them.
module tb_instr_encoder;

  logic        clk;
  logic        reset;
  logic        clear;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  in_op;
  logic [4:0]  in_rt;
  logic [4:0]  in_rn;
  logic [63:0] in_imm;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [7:0]  out_addr;
  logic        err;
  logic [7:0]  err_cnt;

  instr_encoder #(.ADDR_W(8), .ERR_W(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .clear     (clear),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_op     (in_op),
    .in_rt     (in_rt),
    .in_rn     (in_rn),
    .in_imm    (in_imm),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_instr (out_instr),
    .out_addr  (out_addr),
    .err       (err),
    .err_cnt   (err_cnt)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard state ----------------
  // entry = {op[1:0], imm[63:0], addr[7:0], instr[31:0]}
  logic [105:0] exp_q[$];
  logic [7:0]   addr_m;
  logic [7:0]   err_cnt_m;
  int           exp_err;
  int           err_seen;
  int           n_cmp;
  int           n_bad;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] encode(input logic [1:0] op, input logic [4:0] rt,
                                         input logic [4:0] rn, input logic [63:0] imm);
    logic [31:0] w;
    w = 32'h0;
    case (op)
      2'b00:   w = {11'b11111000010, imm[8:0], 2'b00, rn, rt};
      2'b01:   w = {11'b11111000000, imm[8:0], 2'b00, rn, rt};
      2'b10:   w = {8'b10110100, imm[20:2], rt};
      default: w = 32'h0;
    endcase
    return w;
  endfunction

  // ---------------- monitor ----------------
  always begin
    logic [105:0] e;
    logic [31:0]  ins;
    logic [63:0]  dec;
    @(negedge clk);
    #2;
    if (!reset && !clear) begin
      if (err) err_seen++;
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_word: got instr 0x%0h addr %0d with nothing expected", out_instr, out_addr);
        end else if (out_ready) begin
          e = exp_q.pop_front();
          chk("instr", 64'(out_instr), 64'(e[31:0]));
          chk("addr", 64'(out_addr), 64'(e[39:32]));
          ins = out_instr;
          if (e[105:104] == 2'b10) dec = {{43{ins[23]}}, ins[23:5], 2'b00};
          else                     dec = {{55{ins[20]}}, ins[20:12]};
          chk("roundtrip_imm", dec, e[103:40]);
        end else begin
          e = exp_q[0];
          chk("hold_instr", 64'(out_instr), 64'(e[31:0]));
          chk("hold_addr", 64'(out_addr), 64'(e[39:32]));
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Called right after a falling edge; returns right after a falling edge.
  task automatic send(input logic [1:0] op, input logic [4:0] rt, input logic [4:0] rn,
                      input logic [63:0] imm, input bit ok, input logic [31:0] exp_instr,
                      output int waits);
    bit done;
    in_op    = op;
    in_rt    = rt;
    in_rn    = rn;
    in_imm   = imm;
    in_valid = 1'b1;
    waits    = 0;
    done     = 0;
    while (!done) begin
      #1;
      if (in_ready) begin
        @(posedge clk);
        if (ok) begin
          exp_q.push_back({op, imm, addr_m, exp_instr});
          addr_m = addr_m + 8'd1;
        end else begin
          exp_err++;
          if (err_cnt_m != 8'hFF) err_cnt_m = err_cnt_m + 8'd1;
        end
        done = 1;
      end else if (waits >= 200) begin
        chk("accept_timeout", 64'(in_ready), 64'd1);
        done = 1;
      end else begin
        waits++;
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    exp_q.delete();
    addr_m    = 8'd0;
    err_cnt_m = 8'd0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    chk("drain_empty", 64'(exp_q.size()), 64'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int w0, w1, w2;
    longint v;
    logic [1:0] op;
    n_cmp = 0; n_bad = 0; exp_err = 0; err_seen = 0;
    addr_m = 8'd0; err_cnt_m = 8'd0;
    reset = 1'b1; clear = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    in_op = 2'b00; in_rt = 5'd0; in_rn = 5'd0; in_imm = 64'd0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    #1;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_instr", 64'(out_instr), 64'd0);
    chk("rst_out_addr", 64'(out_addr), 64'd0);
    chk("rst_err", 64'(err), 64'd0);
    chk("rst_err_cnt", 64'(err_cnt), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    @(negedge clk);

    // LDUR rt=1 rn=2 imm=-8
    send(2'b00, 5'd1, 5'd2, -64'sd8, 1, 32'hF85F8041, w0);
    drain();

    // STUR then CBZ back to back: second request must not wait
    do_reset();
    send(2'b01, 5'd3, 5'd4, 64'd255, 1, 32'hF80FF083, w0);
    send(2'b10, 5'd5, 5'd0, -64'sd4, 1, 32'hB4FFFFE5, w1);
    chk("no_bubble_waits", 64'(w1), 64'd0);
    drain();

    // Rejected requests, then a valid word at address 0
    do_reset();
    send(2'b00, 5'd1, 5'd1, 64'd256, 0, 32'h0, w0);
    send(2'b10, 5'd1, 5'd0, 64'd6, 0, 32'h0, w0);
    send(2'b11, 5'd1, 5'd1, 64'd0, 0, 32'h0, w0);
    repeat (2) @(negedge clk);
    chk("err_pulses", 64'(err_seen), 64'(exp_err));
    chk("err_cnt_3", 64'(err_cnt), 64'd3);
    send(2'b00, 5'd7, 5'd8, 64'd16, 1, 32'hF8410107, w0);
    drain();

    // Asynchronous reset with a held word and err_cnt=3
    out_ready = 1'b0;
    send(2'b01, 5'd1, 5'd1, 64'd0, 1, 32'hF8000021, w0);
    #3;
    chk("pre_areset_valid", 64'(out_valid), 64'd1);
    reset = 1'b1;
    #1;
    chk("areset_out_valid", 64'(out_valid), 64'd0);
    chk("areset_out_instr", 64'(out_instr), 64'd0);
    chk("areset_out_addr", 64'(out_addr), 64'd0);
    chk("areset_err", 64'(err), 64'd0);
    chk("areset_err_cnt", 64'(err_cnt), 64'd0);
    @(negedge clk);
    do_reset();
    out_ready = 1'b1;

    // Backpressure: held word plus pending request
    out_ready = 1'b0;
    fork
      begin
        send(2'b00, 5'd2, 5'd3, 64'd1, 1, 32'hF8401062, w1);
        send(2'b01, 5'd4, 5'd5, -64'sd1, 1, 32'hF81FF0A4, w2);
      end
      begin
        repeat (2) @(negedge clk);
        #1;
        chk("bp_in_ready_low", 64'(in_ready), 64'd0);
        repeat (5) @(negedge clk);
        out_ready = 1'b1;
      end
    join
    chk("bp_pending_waited", 64'(w2 >= 5), 64'd1);
    drain();

    // 257 words: addresses 0..255 then wrap to 0
    do_reset();
    for (int i = 0; i < 257; i++) begin
      v = longint'(i % 200) - 100;
      send(2'b00, 5'(i), 5'(i + 3), v, 1, encode(2'b00, 5'(i), 5'(i + 3), v), w0);
    end
    drain();
    chk("wrap_next_addr_model", 64'(addr_m), 64'd1);

    // clear with a held word and non-zero err_cnt
    send(2'b11, 5'd0, 5'd0, 64'd0, 0, 32'h0, w0);
    send(2'b00, 5'd0, 5'd0, -64'sd257, 0, 32'h0, w0);
    out_ready = 1'b0;
    send(2'b01, 5'd9, 5'd9, 64'd8, 1, encode(2'b01, 5'd9, 5'd9, 64'd8), w0);
    chk("pre_clear_err_cnt", 64'(err_cnt), 64'd2);
    clear = 1'b1;
    out_ready = 1'b1;
    #1;
    chk("clear_in_ready", 64'(in_ready), 64'd0);
    @(negedge clk);
    clear = 1'b0;
    exp_q.delete();
    addr_m = 8'd0;
    err_cnt_m = 8'd0;
    #1;
    chk("clear_out_valid", 64'(out_valid), 64'd0);
    chk("clear_err_cnt", 64'(err_cnt), 64'd0);
    chk("clear_err", 64'(err), 64'd0);
    @(negedge clk);
    send(2'b10, 5'd31, 5'd0, 64'd8, 1, 32'hB400005F, w0);
    drain();

    // Error counter saturation
    do_reset();
    for (int i = 0; i < 256; i++) send(2'b11, 5'd0, 5'd0, 64'd0, 0, 32'h0, w0);
    repeat (2) @(negedge clk);
    chk("err_cnt_sat", 64'(err_cnt), 64'd255);
    send(2'b10, 5'd0, 5'd0, 64'd1048576, 0, 32'h0, w0);
    repeat (2) @(negedge clk);
    chk("err_cnt_stays", 64'(err_cnt), 64'd255);
    chk("err_pulses_total", 64'(err_seen), 64'(exp_err));

    // Boundary immediates and random valid round trips
    do_reset();
    send(2'b00, 5'd1, 5'd2, -64'sd256, 1, 32'hF8500041, w0);
    send(2'b10, 5'd3, 5'd0, 64'd1048572, 1, 32'hB47FFFE3, w0);
    send(2'b10, 5'd3, 5'd0, -64'sd1048576, 1, 32'hB4800003, w0);
    for (int i = 0; i < 40; i++) begin
      op = 2'($urandom_range(0, 2));
      if (op == 2'b10) v = (longint'($urandom_range(0, 524287)) - 262144) * 4;
      else             v = longint'($urandom_range(0, 511)) - 256;
      in_rt = 5'($urandom_range(0, 31));
      in_rn = 5'($urandom_range(0, 31));
      send(op, in_rt, in_rn, v, 1, encode(op, in_rt, in_rn, v), w0);
    end
    drain();
    chk("final_err_pulses", 64'(err_seen), 64'(exp_err));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/instr_encoder.md
# instr_encoder

Streaming LEGv8 instruction encoder for the LDUR, STUR and CBZ formats. It accepts an operation code, register fields and a 64-bit immediate, range-checks the immediate, and packs a 32-bit instruction word. Each word is tagged with a sequential word address so a loader can write it straight into instruction memory. This block is the inverse of the datapath's immediate sign-extension path: decoding an emitted word with the datapath's extension rules returns the original immediate.

## Interface
- ADDR_W, 8, width of the word-address counter (wraps modulo 2^ADDR_W)
- ERR_W, 8, width of the saturating error counter
- clk  in  1  clock, all state on rising edge
- reset  in  1  asynchronous, active-high reset
- clear  in  1  synchronous: zero address counter and error counter, drop held output
- in_valid  in  1  request present
- in_ready  out  1  request accepted when in_valid && in_ready
- in_op  in  2  00 LDUR, 01 STUR, 10 CBZ, 11 reserved
- in_rt  in  5  Rt field
- in_rn  in  5  Rn field (ignored for CBZ)
- in_imm  in  64  LDUR/STUR: signed byte offset; CBZ: signed byte branch offset
- out_valid  out  1  encoded word held
- out_ready  in  1  consumer takes the word when out_valid && out_ready
- out_instr  out  32  encoded instruction
- out_addr  out  ADDR_W  word address assigned to out_instr
- err  out  1  one-cycle pulse: an accepted request was rejected
- err_cnt  out  ERR_W  count of rejected requests, saturates at all-ones

## Operation
- Datapath: one output register stage with valid/ready handshake. Combinational: in_ready = !clear && (!out_valid || out_ready).
- Validity checks on the accepted request:
  - LDUR/STUR: in_imm[63:8] all equal to in_imm[8]; range −256..255.
  - CBZ: in_imm[1:0] == 00 and in_imm[63:20] all equal to in_imm[20]; range −1048576..1048572.
  - op 11: always invalid.
- Encoding:
  - LDUR: {11'b11111000010, in_imm[8:0], 2'b00, in_rn, in_rt}.
  - STUR: {11'b11111000000, in_imm[8:0], 2'b00, in_rn, in_rt}.
  - CBZ: {8'b10110100, in_imm[20:2], in_rt}.
- Valid accept:
  - out_instr ← encoding; out_addr ← next_addr; out_valid ← 1.
  - next_addr ← next_addr + 1, wrapping from 2^ADDR_W−1 to 0.
- Invalid accept:
  - Output register is not loaded. out_valid ← 0 if the held word was consumed this cycle, otherwise unchanged.
  - next_addr is unchanged.
  - err pulses high the next cycle; err_cnt increments unless already all-ones.
- Held word without consumption (out_ready low, no accept): out_valid, out_instr and out_addr are held stable.
- clear (takes priority over every other event):
  - Next cycle: out_valid=0, next_addr=0, err_cnt=0, err=0.
  - in_ready is low during clear, so no request is lost. A held word is discarded even if out_ready is high.

## Timing
- Reset values: out_valid=0, out_instr=0, out_addr=0, err=0, err_cnt=0, internal next_addr=0. in_ready=1 while reset is deasserted and clear is low.
- Reset asserted mid-stream discards the held word immediately (asynchronous), without waiting for a clock edge.
- Latency: request accepted at edge N gives out_valid=1 after edge N. Error requests give err=1 for the single cycle after edge N.
- Throughput: one word per cycle when out_ready stays high. Simultaneous consume and accept in the same cycle is required, with no bubble.
- Backpressure: out_ready low with out_valid high forces in_ready low next cycle. out_* must not change until consumed.
- Counter wrap: with ADDR_W=8, the word after address 255 carries address 0.
- err_cnt at 255 (ERR_W=8) stays 255; err still pulses.

## Test plan
- Reset, then LDUR rt=1, rn=2, imm=−8 with out_ready=1 -> out_instr=0xF85F8041, out_addr=0, out_valid=1 for one cycle.
- STUR rt=3, rn=4, imm=255 -> 0xF80FF083, addr 0. Then CBZ rt=5, imm=−4 -> 0xB4FFFFE5, addr 1. Back-to-back requests show no bubble.
- LDUR imm=256, CBZ imm=6, and op=11 in sequence -> no out_valid, three err pulses, err_cnt=3, next valid word gets addr 0.
- Hold out_ready=0 for 5 cycles with out_valid=1 and in_valid=1 -> in_ready=0, out_instr/out_addr stable. Release -> held word, then the pending request, each consumed once.
- Issue 257 valid requests -> addresses 0..255 then 0. Then assert clear with a held word -> out_valid=0, err_cnt=0, next word gets addr 0.
- Assert reset asynchronously while out_valid=1 and err_cnt=3 -> all outputs immediately at reset values. Random valid immediates, round-trip decoded -> equal to in_imm.
